// File: rtl/fuzzy_quantizer.sv
// Multi-channel fuzzifier: binary search of a signed sample against a programmable threshold table.
// Optional hysteresis stage is enabled by defining FUZZ_HYST_EN.
module fuzzy_quantizer #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NLEV = 49,
    parameter int unsigned IW   = 7,
    parameter int unsigned NCH  = 2,
    parameter int unsigned STEP = 4,
    parameter int unsigned HYST = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [IW-1:0]            cfg_addr,
    input  logic [DW-1:0]            cfg_data,
    output logic                     cfg_busy,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NCH)-1:0]   in_ch,
    input  logic [DW-1:0]            in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(NCH)-1:0]   out_ch,
    output logic [IW-1:0]            out_idx
);
    localparam int unsigned CW   = $clog2(NCH);
    localparam int unsigned ITER = $clog2(NLEV);
    localparam int unsigned AW   = $clog2(NLEV - 1);
    localparam int unsigned CNTW = $clog2(ITER + 1);
    localparam int unsigned MIDL = (NLEV - 1) / 2;

    // Elaboration-time parameter sanity
    if ((1 << IW) < NLEV) begin : g_chk_iw
        $error("IW too small for NLEV");
    end
    if (NCH < 2) begin : g_chk_nch
        $error("NCH must be at least 2");
    end
    if (HYST >= (1 << (DW - 1))) begin : g_chk_hyst
        $error("HYST exceeds sample range");
    end

`ifdef FUZZ_HYST_EN
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_HYST, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;
`endif

    state_t                 state, state_n;
    logic [CNTW-1:0]        cnt, cnt_n;
    logic [IW-1:0]          lo, lo_n, hi, hi_n, mid;
    logic [IW:0]            sum;
    logic [DW-1:0]          x, x_n;
    logic [CW-1:0]          ch, ch_n;
    logic                   ov_n, rdy_n, busy_n, wr_en;
    logic [IW-1:0]          oi_n;
    logic [CW-1:0]          oc_n;
    logic signed [DW-1:0]   t [NLEV-1];
    logic signed [DW-1:0]   t_mid;
    logic signed [DW:0]     x_ext, tm_ext;
    logic                   le_mid;

`ifdef FUZZ_HYST_EN
    logic [IW-1:0]          prev [NCH];
    logic [IW-1:0]          p, hres;
    logic signed [DW-1:0]   tp, tr;
    logic signed [DW+1:0]   x2, tp2, tr2, hyst2;
    logic                   ch_ok, hold, prev_we;

    // Suppress single-level moves that stay within HYST of the crossed threshold
    always_comb begin
        ch_ok = ({1'b0, ch} < (CW+1)'(NCH));
        p     = prev[ch];
        tp    = t[AW'(p)];
        tr    = t[AW'(lo)];
        x2    = {{2{x[DW-1]}}, x};
        tp2   = {{2{tp[DW-1]}}, tp};
        tr2   = {{2{tr[DW-1]}}, tr};
        hyst2 = (DW+2)'(HYST);
        hold  = ch_ok && (((lo == p + IW'(1)) && (x2 <= tp2 + hyst2)) ||
                          ((lo + IW'(1) == p) && (x2 > tr2 - hyst2)));
        hres  = hold ? p : lo;
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lo_n    = lo;
        hi_n    = hi;
        x_n     = x;
        ch_n    = ch;
        ov_n    = out_valid;
        oi_n    = out_idx;
        oc_n    = out_ch;
        wr_en   = 1'b0;
`ifdef FUZZ_HYST_EN
        prev_we = 1'b0;
`endif
        sum     = {1'b0, lo} + {1'b0, hi};
        mid     = IW'(sum >> 1);
        t_mid   = t[AW'(mid)];
        x_ext   = {x[DW-1], x};
        tm_ext  = {t_mid[DW-1], t_mid};
        le_mid  = (x_ext <= tm_ext);

        case (state)
            S_IDLE: begin
                wr_en = cfg_we && (cfg_addr < IW'(NLEV - 1));
                if (in_valid) begin
                    state_n = S_SEARCH;
                    x_n     = in_data;
                    ch_n    = in_ch;
                    lo_n    = '0;
                    hi_n    = IW'(NLEV - 1);
                    cnt_n   = '0;
                end
            end
            S_SEARCH: begin
                if (lo != hi) begin
                    if (le_mid) hi_n = mid;
                    else        lo_n = mid + IW'(1);
                end
                cnt_n = cnt + CNTW'(1);
                if (cnt == CNTW'(ITER - 1)) begin
`ifdef FUZZ_HYST_EN
                    state_n = S_HYST;
`else
                    state_n = S_DONE;
                    ov_n    = 1'b1;
                    oi_n    = lo_n;
                    oc_n    = ch;
`endif
                end
            end
`ifdef FUZZ_HYST_EN
            S_HYST: begin
                state_n = S_DONE;
                ov_n    = 1'b1;
                oi_n    = hres;
                oc_n    = ch;
                prev_we = ch_ok;
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                    ov_n    = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        rdy_n  = (state_n == S_IDLE);
        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lo        <= '0;
            hi        <= '0;
            x         <= '0;
            ch        <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_ch    <= '0;
            in_ready  <= 1'b1;
            cfg_busy  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lo        <= lo_n;
            hi        <= hi_n;
            x         <= x_n;
            ch        <= ch_n;
            out_valid <= ov_n;
            out_idx   <= oi_n;
            out_ch    <= oc_n;
            in_ready  <= rdy_n;
            cfg_busy  <= busy_n;
        end
    end

    // Threshold table; reset default is an evenly spaced ramp centred on level MIDL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(NLEV) - 1; k++)
                t[AW'(k)] <= DW'((k - int'(MIDL)) * int'(STEP));
        end else if (wr_en) begin
            t[AW'(cfg_addr)] <= cfg_data;
        end
    end

`ifdef FUZZ_HYST_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < int'(NCH); c++)
                prev[CW'(c)] <= IW'(MIDL);
        end else if (prev_we) begin
            prev[ch] <= hres;
        end
    end
`endif

endmodule
